// File: rtl/param_stack.sv
// param_stack: LIFO stack of DEPTH entries x WIDTH bits with combinational
// top-of-stack output, occupancy decodes and optional sticky error flags.
//
// Ports:
//   clk          clock, all state updates on the rising edge
//   rst          asynchronous active-high reset (sp and error flags)
//   clr          synchronous flush, overrides push/pop for that cycle
//   push, pop    operation requests; push&pop on a non-empty stack replaces the top
//   din          data to push
//   dout         current top entry, zero when empty
//   empty, full  count==0 / count==DEPTH
//   almost_full  count>=AF_LEVEL
//   count        current entry count, 0..DEPTH
//   err_ovf      sticky overflow flag (push while full)
//   err_unf      sticky underflow flag (pop while empty)
//   err_clr      synchronous clear of both error flags
//
// Build option: define PARAM_STACK_ERR_FLAGS_EN to implement the error flags.
// Without it err_ovf/err_unf are tied low and err_clr is ignored.

module param_stack #(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned DEPTH    = 32,
    parameter int unsigned AF_LEVEL = DEPTH - 2,
    localparam int unsigned AW      = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             empty,
    output logic             full,
    output logic             almost_full,
    output logic [AW:0]      count,
    output logic             err_ovf,
    output logic             err_unf,
    input  logic             err_clr
);

    localparam logic [AW:0] SpOne   = (AW+1)'(1);
    localparam logic [AW:0] FullCnt = (AW+1)'(DEPTH);
    localparam logic [AW:0] AfCnt   = (AW+1)'(AF_LEVEL);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      sp_q, sp_d;
    logic [AW:0]      sp_m1;
    logic [AW-1:0]    top_idx;
    logic [AW-1:0]    waddr;
    logic             we;
    logic             ovf_evt;
    logic             unf_evt;

    // Index of the current top entry; only meaningful when the stack is not empty.
    assign sp_m1   = sp_q - SpOne;
    assign top_idx = sp_m1[AW-1:0];

    assign empty       = (sp_q == '0);
    assign full        = (sp_q == FullCnt);
    assign almost_full = (sp_q >= AfCnt);
    assign count       = sp_q;
    assign dout        = empty ? '0 : mem_q[top_idx];

    always_comb begin
        sp_d    = sp_q;
        we      = 1'b0;
        waddr   = sp_q[AW-1:0];
        ovf_evt = 1'b0;
        unf_evt = 1'b0;
        if (clr) begin
            sp_d = '0;
        end else if (push && pop) begin
            // Replace the top in place; on an empty stack this degrades to a plain push.
            we = 1'b1;
            if (empty) begin
                waddr = '0;
                sp_d  = SpOne;
            end else begin
                waddr = top_idx;
            end
        end else if (push) begin
            if (full) begin
                ovf_evt = 1'b1;
            end else begin
                we   = 1'b1;
                sp_d = sp_q + SpOne;
            end
        end else if (pop) begin
            if (empty) begin
                unf_evt = 1'b1;
            end else begin
                sp_d = sp_m1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sp_q <= '0;
        end else begin
            sp_q <= sp_d;
        end
    end

    // Storage is deliberately not reset; sp alone defines which entries are live.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= din;
        end
    end

`ifdef PARAM_STACK_ERR_FLAGS_EN
    logic ovf_q;
    logic unf_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else if (err_clr) begin
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            if (ovf_evt) ovf_q <= 1'b1;
            if (unf_evt) unf_q <= 1'b1;
        end
    end

    assign err_ovf = ovf_q;
    assign err_unf = unf_q;
`else
    logic unused_err;
    assign unused_err = ^{err_clr, ovf_evt, unf_evt};
    assign err_ovf    = 1'b0;
    assign err_unf    = 1'b0;
`endif

endmodule
